// File: rtl/clkdiv_multi_if.sv
// Control/status bundle for clkdiv_multi: run/restart controls, the
// half-period load port, and the per-channel divided outputs.
interface clkdiv_multi_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 27
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              en;
    logic              sync;
    logic              ld_valid;
    logic [CH_W-1:0]   ld_ch;
    logic [CNT_W-1:0]  ld_div;
    logic              ld_err;
    logic [NUM_CH-1:0] sclk_out;
    logic [NUM_CH-1:0] tick;

    modport master (
        output en, sync, ld_valid, ld_ch, ld_div,
        input  ld_err, sclk_out, tick
    );

    modport slave (
        input  en, sync, ld_valid, ld_ch, ld_div,
        output ld_err, sclk_out, tick
    );
endinterface

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: per channel a 50% square wave
// and a one-cycle tick per toggle; reloads commit only at a wrap or sync.
module clkdiv_multi #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 27,
    parameter int DIV_RST = 10000
) (
    input logic           clk,
    input logic           rst_n,
    clkdiv_multi_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CNT_W-1:0]  cnt_q      [NUM_CH];
    logic [CNT_W-1:0]  cnt_d      [NUM_CH];
    logic [CNT_W-1:0]  hp_q       [NUM_CH];
    logic [CNT_W-1:0]  hp_d       [NUM_CH];
    logic [CNT_W-1:0]  pend_q     [NUM_CH];
    logic [CNT_W-1:0]  pend_d     [NUM_CH];
    logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
    logic [NUM_CH-1:0] sclk_q, sclk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              ld_err_q, ld_err_d;

    logic              ld_ok;
    logic [NUM_CH-1:0] ld_hit;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] eff_vld;
    logic [CNT_W-1:0]  eff_pend   [NUM_CH];

    always_comb begin
        ld_ok    = bus.ld_valid && (bus.ld_div != '0) && (int'(bus.ld_ch) < NUM_CH);
        ld_err_d = bus.ld_valid && !ld_ok;
        ld_hit   = '0;
        wrap     = '0;
        eff_vld  = '0;
        eff_pend = '{default: '0};
        cnt_d    = cnt_q;
        hp_d     = hp_q;
        pend_d   = pend_q;
        pend_vld_d = pend_vld_q;
        sclk_d   = sclk_q;
        tick_d   = '0;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            // A load arriving in a commit cycle is treated as already pending,
            // so it takes effect at that same wrap/sync instead of one later.
            ld_hit[i]   = ld_ok && (bus.ld_ch == CH_W'(i));
            eff_vld[i]  = pend_vld_q[i] | ld_hit[i];
            eff_pend[i] = ld_hit[i] ? bus.ld_div : pend_q[i];
            wrap[i]     = (cnt_q[i] == hp_q[i] - CNT_W'(1));

            pend_d[i]     = eff_pend[i];
            pend_vld_d[i] = eff_vld[i];

            if (bus.sync) begin
                cnt_d[i]  = '0;
                sclk_d[i] = 1'b0;
                if (eff_vld[i]) begin
                    hp_d[i]       = eff_pend[i];
                    pend_vld_d[i] = 1'b0;
                end
            end else if (bus.en) begin
                if (wrap[i]) begin
                    cnt_d[i]  = '0;
                    sclk_d[i] = ~sclk_q[i];
                    tick_d[i] = 1'b1;
                    if (eff_vld[i]) begin
                        hp_d[i]       = eff_pend[i];
                        pend_vld_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '{default: '0};
            hp_q       <= '{default: CNT_W'(DIV_RST)};
            pend_q     <= '{default: '0};
            pend_vld_q <= '0;
            sclk_q     <= '0;
            tick_q     <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hp_q       <= hp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sclk_q     <= sclk_d;
            tick_q     <= tick_d;
            ld_err_q   <= ld_err_d;
        end
    end

    assign bus.sclk_out = sclk_q;
    assign bus.tick     = tick_q;
    assign bus.ld_err   = ld_err_q;
endmodule

// File: tb/tb_clkdiv_multi.sv
// Randomised and directed bench for clkdiv_multi against a countdown-based
// behavioural model of the divider.
module tb_clkdiv_multi;
    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DR  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clkdiv_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clkdiv_multi #(.NUM_CH(NCH), .CNT_W(CW), .DIV_RST(DR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: cycles remaining until the next toggle, current and pending half-period.
    int m_rem  [NCH];
    int m_hp   [NCH];
    int m_pend [NCH];
    logic [NCH-1:0] m_sclk, m_tick;
    logic           m_err;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_hp[i] = DR; m_rem[i] = DR; m_pend[i] = -1;
        end
        m_sclk = '0; m_tick = '0; m_err = 1'b0;
    endfunction

    function automatic void model_step();
        bit legal;
        legal = bus.ld_valid && (bus.ld_div != 0) && (int'(bus.ld_ch) < NCH);
        m_err = bus.ld_valid && !legal;
        for (int i = 0; i < NCH; i++) begin
            int np;
            np = (legal && int'(bus.ld_ch) == i) ? int'(bus.ld_div) : m_pend[i];
            m_tick[i] = 1'b0;
            if (bus.sync) begin
                m_sclk[i] = 1'b0;
                if (np > 0) begin m_hp[i] = np; np = -1; end
                m_rem[i] = m_hp[i];
            end else if (bus.en) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_sclk[i] = ~m_sclk[i];
                    m_tick[i] = 1'b1;
                    if (np > 0) begin m_hp[i] = np; np = -1; end
                    m_rem[i] = m_hp[i];
                end
            end
            m_pend[i] = np;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic quiet_inputs();
        bus.en = 1'b0; bus.sync = 1'b0; bus.ld_valid = 1'b0;
        bus.ld_ch = '0; bus.ld_div = '0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst_n = 1'b0;
        #12;
        n_chk++; if (bus.sclk_out !== 3'b000) $display("FAIL reset_sclk got %b exp 000", bus.sclk_out); else n_pass++;
        n_chk++; if (bus.tick !== 3'b000) $display("FAIL reset_tick got %b exp 000", bus.tick); else n_pass++;
        n_chk++; if (bus.ld_err !== 1'b0) $display("FAIL reset_ld_err got %b exp 0", bus.ld_err); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        bus.en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            n_chk++;
            if (bus.tick[0] !== ((k % 4) == 0) || bus.sclk_out[0] !== (((k / 4) % 2) == 1))
                $display("FAIL basic_ch0 cyc %0d got tick=%b sclk=%b exp tick=%b sclk=%b",
                         k, bus.tick[0], bus.sclk_out[0], (k % 4) == 0, ((k / 4) % 2) == 1);
            else n_pass++;
            n_chk++;
            if ({bus.ld_err, bus.tick, bus.sclk_out} !== {m_err, m_tick, m_sclk})
                $display("FAIL basic_model cyc %0d got %b exp %b", k,
                         {bus.ld_err, bus.tick, bus.sclk_out}, {m_err, m_tick, m_sclk});
            else n_pass++;
        end
    endtask

    task automatic test_load_midperiod();
        int ticks1;
        int guard = 0;
        while (m_rem[1] != DR - 1 && guard < 20) begin step(); guard++; end
        n_chk++; if (m_rem[1] != DR - 1) $display("FAIL ldmid_sync got rem %0d exp %0d", m_rem[1], DR - 1); else n_pass++;
        bus.ld_valid = 1'b1; bus.ld_ch = 2'd1; bus.ld_div = CW'(2);
        step();
        bus.ld_valid = 1'b0;
        ticks1 = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.tick[1] === 1'b1) ticks1++;
            n_chk++;
            if ({bus.ld_err, bus.tick, bus.sclk_out} !== {m_err, m_tick, m_sclk})
                $display("FAIL ldmid_model cyc %0d got %b exp %b", k,
                         {bus.ld_err, bus.tick, bus.sclk_out}, {m_err, m_tick, m_sclk});
            else n_pass++;
        end
        n_chk++; if (ticks1 !== 6) $display("FAIL ldmid_ticks got %0d exp 6", ticks1); else n_pass++;
    endtask

    task automatic test_load_err();
        bus.ld_valid = 1'b1; bus.ld_ch = 2'd0; bus.ld_div = '0;
        step();
        bus.ld_valid = 1'b0;
        n_chk++; if (bus.ld_err !== 1'b1) $display("FAIL lderr_zero got %b exp 1", bus.ld_err); else n_pass++;
        step();
        n_chk++; if (bus.ld_err !== 1'b0) $display("FAIL lderr_zero_clear got %b exp 0", bus.ld_err); else n_pass++;
        bus.ld_valid = 1'b1; bus.ld_ch = 2'd3; bus.ld_div = CW'(5);
        step();
        bus.ld_valid = 1'b0;
        n_chk++; if (bus.ld_err !== 1'b1) $display("FAIL lderr_ch got %b exp 1", bus.ld_err); else n_pass++;
        for (int k = 1; k <= 16; k++) begin
            step();
            n_chk++;
            if ({bus.ld_err, bus.tick, bus.sclk_out} !== {m_err, m_tick, m_sclk})
                $display("FAIL lderr_model cyc %0d got %b exp %b", k,
                         {bus.ld_err, bus.tick, bus.sclk_out}, {m_err, m_tick, m_sclk});
            else n_pass++;
        end
    endtask

    task automatic test_enable();
        logic [NCH-1:0] held;
        int guard = 0;
        while (m_rem[0] != 2 && guard < 20) begin step(); guard++; end
        n_chk++; if (m_rem[0] != 2) $display("FAIL en_sync got rem %0d exp 2", m_rem[0]); else n_pass++;
        bus.en = 1'b0;
        held = bus.sclk_out;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_chk++;
            if (bus.tick !== 3'b000 || bus.sclk_out !== held)
                $display("FAIL en_hold cyc %0d got tick=%b sclk=%b exp tick=000 sclk=%b",
                         k, bus.tick, bus.sclk_out, held);
            else n_pass++;
        end
        bus.en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_chk++;
            if ({bus.ld_err, bus.tick, bus.sclk_out} !== {m_err, m_tick, m_sclk})
                $display("FAIL en_resume cyc %0d got %b exp %b", k,
                         {bus.ld_err, bus.tick, bus.sclk_out}, {m_err, m_tick, m_sclk});
            else n_pass++;
        end
    endtask

    task automatic test_wrap_load();
        int guard = 0;
        while (m_rem[0] != 1 && guard < 20) begin step(); guard++; end
        bus.ld_valid = 1'b1; bus.ld_ch = 2'd0; bus.ld_div = CW'(1);
        step();
        bus.ld_valid = 1'b0;
        n_chk++; if (bus.tick[0] !== 1'b1) $display("FAIL wrapld_tick got %b exp 1", bus.tick[0]); else n_pass++;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_chk++;
            if (bus.tick[0] !== 1'b1 || {bus.tick, bus.sclk_out} !== {m_tick, m_sclk})
                $display("FAIL wrapld_fast cyc %0d got %b exp %b", k,
                         {bus.tick, bus.sclk_out}, {m_tick, m_sclk});
            else n_pass++;
        end
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        n_chk++;
        if (bus.sclk_out !== 3'b000 || bus.tick !== 3'b000)
            $display("FAIL sync_clear got sclk=%b tick=%b exp 000/000", bus.sclk_out, bus.tick);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_chk++;
            if ({bus.ld_err, bus.tick, bus.sclk_out} !== {m_err, m_tick, m_sclk})
                $display("FAIL sync_after cyc %0d got %b exp %b", k,
                         {bus.ld_err, bus.tick, bus.sclk_out}, {m_err, m_tick, m_sclk});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.en       = ($urandom % 8) != 0;
            bus.sync     = ($urandom % 50) == 0;
            bus.ld_valid = ($urandom % 6) == 0;
            bus.ld_ch    = 2'($urandom % 4);
            bus.ld_div   = CW'($urandom % 5);
            step();
            n_chk++;
            if ({bus.ld_err, bus.tick, bus.sclk_out} !== {m_err, m_tick, m_sclk})
                $display("FAIL random cyc %0d got %b exp %b", k,
                         {bus.ld_err, bus.tick, bus.sclk_out}, {m_err, m_tick, m_sclk});
            else n_pass++;
        end
        quiet_inputs();
    endtask

    task automatic test_async_reset();
        int guard = 0;
        bus.en = 1'b1;
        while (m_sclk == '0 && guard < 40) begin step(); guard++; end
        bus.en = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_ch = 2'd0; bus.ld_div = CW'(7);
        step();
        bus.ld_valid = 1'b0;
        n_chk++; if (bus.sclk_out === 3'b000) $display("FAIL arst_pre got sclk=%b exp nonzero", bus.sclk_out); else n_pass++;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.sclk_out !== 3'b000 || bus.tick !== 3'b000 || bus.ld_err !== 1'b0)
            $display("FAIL arst_clear got sclk=%b tick=%b err=%b exp 000/000/0",
                     bus.sclk_out, bus.tick, bus.ld_err);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_chk++;
            if (bus.tick[0] !== ((k % 4) == 0) || {bus.tick, bus.sclk_out} !== {m_tick, m_sclk})
                $display("FAIL arst_after cyc %0d got %b exp %b (ch0 tick exp %b)", k,
                         {bus.tick, bus.sclk_out}, {m_tick, m_sclk}, (k % 4) == 0);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_load_midperiod();
        test_load_err();
        test_enable();
        test_wrap_load();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
